// File: rtl/lb_align_writer.sv
// Line-buffer write stage: rotates the quadrupler's 32-pixel window into an aligned
// 16-pixel word with byte enables, and runs the background-clear sequence.
module lb_align_writer #(
  parameter bit TRANSPARENT_ZERO = 1'b1,
  parameter int LB_WORDS         = 128
) (
  input  logic         clk_draw,
  input  logic         rst_draw_n,
  input  logic [6:0]   lb_addr,
  input  logic [255:0] unaligned_pixels,
  input  logic [31:0]  unaligned_valid_mask,
  input  logic [3:0]   alignment_shift,
  input  logic         clear_req,
  input  logic [7:0]   clear_color,
  output logic         lb_wr_en,
  output logic [6:0]   lb_wr_addr,
  output logic [127:0] lb_wr_data,
  output logic [15:0]  lb_wr_be,
  output logic         busy,
  output logic         overlap_err
);

  localparam logic [6:0] LAST_ADDR = 7'(LB_WORDS - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  state_t       state_q;
  logic [6:0]   cnt_q;
  logic [7:0]   color_q;
  logic         busy_q;
  logic         fin_q;
  logic         ovl_q;
  logic         vld_p1_q;
  logic [127:0] pix_p1_q;
  logic [15:0]  be_p1_q;
  logic [6:0]   addr_p1_q;
  logic         wr_en_q;
  logic [6:0]   wr_addr_q;
  logic [127:0] wr_data_q;
  logic [15:0]  wr_be_q;

  logic [127:0] aligned_d;
  logic [15:0]  en_d;
  logic         drop;
  logic         start;
  logic         draw_ok;

  // Source pixel for output slot j; the 5-bit wrap gives the mod-32 rotation.
  function automatic logic [4:0] src_idx(input int j, input logic [3:0] s);
    return 5'(j) - {1'b0, s};
  endfunction

  always_comb begin
    aligned_d = '0;
    en_d      = '0;
    for (int j = 0; j < 16; j++) begin
      aligned_d[j*8 +: 8] = unaligned_pixels[src_idx(j, alignment_shift)*8 +: 8];
      en_d[j] = (TRANSPARENT_ZERO && (aligned_d[j*8 +: 8] == 8'h00))
                ? 1'b0 : unaligned_valid_mask[src_idx(j, alignment_shift)];
    end
  end

  // A draw in the clear_req cycle is dropped as well, since busy rises right after it.
  assign drop    = busy_q | clear_req;
  assign start   = clear_req & ~busy_q;
  assign draw_ok = (|en_d) & ~drop;

  // ---- stage 1: aligned word, enables, address ----
  always_ff @(posedge clk_draw) begin
    pix_p1_q  <= aligned_d;
    be_p1_q   <= en_d;
    addr_p1_q <= lb_addr;
  end

  // ---- stage 2: write port, clear sequencer, status ----
  // The clear_req cycle plus the single DRAIN cycle let the two in-flight draws
  // reach the port before the first clear write. busy holds one cycle past the
  // final write (fin_q) so draws and clears arriving then are still rejected.
  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      color_q   <= '0;
      busy_q    <= 1'b0;
      fin_q     <= 1'b0;
      ovl_q     <= 1'b0;
      vld_p1_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
    end else begin
      vld_p1_q <= draw_ok;
      busy_q   <= start | (state_q != IDLE) | fin_q;
      fin_q    <= 1'b0;
      wr_en_q  <= 1'b0;
      if ((|unaligned_valid_mask) && drop) begin
        ovl_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (vld_p1_q) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_p1_q;
            wr_data_q <= pix_p1_q;
            wr_be_q   <= be_p1_q;
          end
          if (start) begin
            color_q <= clear_color;
            state_q <= DRAIN;
          end
        end
        DRAIN, CLEAR: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= cnt_q;
          wr_data_q <= {16{color_q}};
          wr_be_q   <= 16'hFFFF;
          if (state_q == DRAIN) begin
            cnt_q   <= cnt_q + 7'd1;
            state_q <= CLEAR;
          end else if (cnt_q == LAST_ADDR) begin
            cnt_q   <= '0;
            fin_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 7'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lb_wr_en    = wr_en_q;
  assign lb_wr_addr  = wr_addr_q;
  assign lb_wr_data  = wr_data_q;
  assign lb_wr_be    = wr_be_q;
  assign busy        = busy_q;
  assign overlap_err = ovl_q;

endmodule

// File: tb/tb_lb_align_writer.sv
// Scoreboard bench for lb_align_writer: a cycle-stamped model of expected writes,
// busy window and sticky overlap flag, checked by an independent monitor.
module tb_lb_align_writer;

  logic         clk_draw = 1'b0;
  logic         rst_draw_n = 1'b1;
  logic [6:0]   lb_addr = '0;
  logic [255:0] unaligned_pixels = '0;
  logic [31:0]  unaligned_valid_mask = '0;
  logic [3:0]   alignment_shift = '0;
  logic         clear_req = 1'b0;
  logic [7:0]   clear_color = '0;
  logic         lb_wr_en;
  logic [6:0]   lb_wr_addr;
  logic [127:0] lb_wr_data;
  logic [15:0]  lb_wr_be;
  logic         busy;
  logic         overlap_err;

  always #5 clk_draw = ~clk_draw;

  lb_align_writer #(.TRANSPARENT_ZERO(1'b1), .LB_WORDS(128)) dut (
    .clk_draw(clk_draw), .rst_draw_n(rst_draw_n), .lb_addr(lb_addr),
    .unaligned_pixels(unaligned_pixels), .unaligned_valid_mask(unaligned_valid_mask),
    .alignment_shift(alignment_shift), .clear_req(clear_req), .clear_color(clear_color),
    .lb_wr_en(lb_wr_en), .lb_wr_addr(lb_wr_addr), .lb_wr_data(lb_wr_data),
    .lb_wr_be(lb_wr_be), .busy(busy), .overlap_err(overlap_err)
  );

  typedef struct {
    int           cyc;
    logic [6:0]   addr;
    logic [127:0] data;
    logic [15:0]  be;
  } wr_t;

  wr_t          exp_q[$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  int           clr_c = -1000;
  int           ovl_from = 32'h3fffffff;
  logic         started = 1'b0;
  logic [6:0]   last_addr = '0;
  logic [127:0] last_data = '0;
  logic [15:0]  last_be = '0;

  always @(posedge clk_draw) cyc <= cyc + 1;

  // busy is expected high for the 130 cycles following an accepted clear_req
  function automatic bit m_busy(input int n);
    return (n >= clr_c + 1) && (n <= clr_c + 130);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    clr_c     = -1000;
    ovl_from  = 32'h3fffffff;
    last_addr = '0;
    last_data = '0;
    last_be   = '0;
  endtask

  // Drive one cycle of input, record what the write port must show 2 cycles later.
  task automatic step(input logic [255:0] u, input logic [31:0] v, input logic [3:0] s,
                      input logic [6:0] a, input logic cr, input logic [7:0] col);
    int           n;
    int           k;
    int           si;
    bit           busy_now;
    logic [7:0]   p;
    logic [127:0] d;
    logic [15:0]  b;
    wr_t          w;
    n = cyc;
    unaligned_pixels     = u;
    unaligned_valid_mask = v;
    alignment_shift      = s;
    lb_addr              = a;
    clear_req            = cr;
    clear_color          = col;
    busy_now = m_busy(n);
    if (cr && !busy_now) begin
      clr_c = n;
      for (int i = 0; i < 128; i++) begin
        w.cyc = n + 2 + i; w.addr = 7'(i); w.data = {16{col}}; w.be = 16'hFFFF;
        exp_q.push_back(w);
      end
    end
    if (v != 0) begin
      if (busy_now || cr) begin
        if (ovl_from > n + 1) ovl_from = n + 1;
      end else begin
        si = int'(s);
        d = '0;
        b = '0;
        for (int j = 0; j < 16; j++) begin
          k = (j - si + 32) % 32;
          p = u[k*8 +: 8];
          d[j*8 +: 8] = p;
          b[j] = v[k] && (p != 8'h00);
        end
        if (b != 0) begin
          w.cyc = n + 2; w.addr = a; w.data = d; w.be = b;
          exp_q.push_back(w);
        end
      end
    end
    @(posedge clk_draw);
    #1;
  endtask

  task automatic idle();
    step('0, '0, 4'd0, 7'd0, 1'b0, 8'd0);
  endtask

  task automatic rand_step(input int clr_pct);
    logic [255:0] u;
    logic [31:0]  v;
    logic         cr;
    for (int i = 0; i < 32; i++)
      u[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: v = '0;
      2: v = '1;
      default: v = 32'h0000FFFF;
    endcase
    cr = ($urandom_range(0, 99) < clr_pct);
    step(u, v, 4'($urandom_range(0, 15)), 7'($urandom_range(0, 127)), cr,
         8'($urandom_range(0, 255)));
  endtask

  task automatic wait_not_busy();
    int guard = 0;
    while (m_busy(cyc) && guard < 300) begin
      idle();
      guard++;
    end
    if (m_busy(cyc)) chk("busy_wait_timeout", 1, 0);
  endtask

  // Monitor: compares the port against the scoreboard every cycle, away from the edge.
  always @(negedge clk_draw) begin
    wr_t e;
    if (started && rst_draw_n) begin
      chk("busy", busy, m_busy(cyc));
      chk("overlap_err", overlap_err, cyc >= ovl_from);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missing_write: addr %0h due cycle %0d, absent through cycle %0d",
                 e.addr, e.cyc, cyc);
      end
      if (lb_wr_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0h data %0h be %0h, none required (cycle %0d)",
                   lb_wr_addr, lb_wr_data, lb_wr_be, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_addr", lb_wr_addr, e.addr);
          chk("wr_data", lb_wr_data, e.data);
          chk("wr_be", lb_wr_be, e.be);
          last_addr = e.addr;
          last_data = e.data;
          last_be   = e.be;
        end
      end else begin
        chk("hold_addr", lb_wr_addr, last_addr);
        chk("hold_data", lb_wr_data, last_data);
        chk("hold_be", lb_wr_be, last_be);
      end
    end
  end

  initial begin
    logic [255:0] u;
    int guard;
    #1 rst_draw_n = 1'b0;
    repeat (3) @(posedge clk_draw);
    #1;
    chk("rst_wr_en", lb_wr_en, 0);
    chk("rst_wr_addr", lb_wr_addr, 0);
    chk("rst_wr_data", lb_wr_data, 0);
    chk("rst_wr_be", lb_wr_be, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overlap", overlap_err, 0);
    rst_draw_n = 1'b1;
    started = 1'b1;

    // aligned word, no shift
    u = '0;
    for (int i = 0; i < 16; i++) u[i*8 +: 8] = 8'(8'h11 + i);
    step(u, 32'h0000FFFF, 4'd0, 7'd5, 1'b0, 8'd0);
    // shift 3 pulls the tail of the previous half into slots 0-2
    for (int i = 0; i < 16; i++) u[i*8 +: 8] = 8'(8'h01 + i);
    for (int i = 16; i < 32; i++) u[i*8 +: 8] = 8'(8'hA0 + i - 16);
    step(u, '1, 4'd3, 7'd9, 1'b0, 8'd0);
    // transparent zeros in slots 4-7, then same word with no valid bits
    for (int i = 0; i < 32; i++) u[i*8 +: 8] = 8'(8'h40 + i);
    for (int i = 4; i < 8; i++) u[i*8 +: 8] = 8'h00;
    step(u, '1, 4'd0, 7'd12, 1'b0, 8'd0);
    step(u, '0, 4'd0, 7'd13, 1'b0, 8'd0);
    step(u, 32'hFFFF0000, 4'd15, 7'd127, 1'b0, 8'd0);
    repeat (3) idle();
    repeat (60) rand_step(0);

    // clear with two draws in flight, a repeated clear_req and a draw during CLEAR
    for (int i = 0; i < 32; i++) u[i*8 +: 8] = 8'(8'h80 + i);
    step(u, '1, 4'd2, 7'd20, 1'b0, 8'd0);
    step(u, '1, 4'd5, 7'd21, 1'b0, 8'd0);
    step('0, '0, 4'd0, 7'd0, 1'b1, 8'h3C);
    repeat (47) idle();
    step('0, '0, 4'd0, 7'd0, 1'b1, 8'h55);
    repeat (10) idle();
    step(u, '1, 4'd0, 7'd33, 1'b0, 8'd0);
    wait_not_busy();
    repeat (3) idle();
    repeat (5) rand_step(0);

    repeat (300) rand_step(1);
    wait_not_busy();
    repeat (3) idle();

    // reset while the clear is writing address 40
    step('0, '0, 4'd0, 7'd0, 1'b1, 8'hC3);
    guard = 0;
    while (cyc < clr_c + 42 && guard < 100) begin
      idle();
      guard++;
    end
    chk("reset_point_addr40", lb_wr_addr, 7'd40);
    rst_draw_n = 1'b0;
    #1;
    chk("midrst_wr_en", lb_wr_en, 0);
    chk("midrst_wr_addr", lb_wr_addr, 0);
    chk("midrst_wr_data", lb_wr_data, 0);
    chk("midrst_wr_be", lb_wr_be, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_overlap", overlap_err, 0);
    model_reset();
    repeat (2) @(posedge clk_draw);
    #1 rst_draw_n = 1'b1;
    repeat (5) idle();
    step('0, '0, 4'd0, 7'd0, 1'b1, 8'h5A);
    wait_not_busy();

    guard = 0;
    while (exp_q.size() > 0 && guard < 400) begin
      idle();
      guard++;
    end
    chk("drain_pending", exp_q.size(), 0);
    repeat (2) idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
